frequency_measurement_scheduler: RTL and testbench

//  Sequences one frequency-analyzer measurement cycle: clear, arm, timed window, readout.

---
 rtl/frequency_measurement_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_frequency_measurement_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_measurement_scheduler.sv
// Sequences one analyzer measurement: clear, arm, timed window, readout.
// Ports: clock/reset, cfg_* config, cmd_start/cmd_abort, readout_done irq;
//   start/stop/clear analyzer controls, busy, aborted, timeout_error,
//   window_count (completed windows since reset).
module frequency_measurement_scheduler #(
    parameter int WINDOW_WIDTH           = 32,
    parameter int CLEAR_PULSE_CYCLES     = 4,
    parameter int ARM_PULSE_CYCLES       = 2,
    parameter int READOUT_TIMEOUT_CYCLES = 1024,
    parameter int COUNT_WIDTH            = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WINDOW_WIDTH-1:0] cfg_window_cycles,
    input  logic                    cfg_repeat,
    input  logic                    cmd_start,
    input  logic                    cmd_abort,
    input  logic                    readout_done,
    output logic                    start,
    output logic                    stop,
    output logic                    clear,
    output logic                    busy,
    output logic                    aborted,
    output logic                    timeout_error,
    output logic [COUNT_WIDTH-1:0]  window_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ARM,
        S_MEASURE,
        S_READOUT,
        S_RELEASE
    } state_t;

    localparam logic [WINDOW_WIDTH-1:0] CLR_LAST =
        WINDOW_WIDTH'(CLEAR_PULSE_CYCLES - 1);
    localparam logic [WINDOW_WIDTH-1:0] ARM_LAST =
        WINDOW_WIDTH'(ARM_PULSE_CYCLES - 1);
    localparam logic [WINDOW_WIDTH-1:0] TO_LAST =
        WINDOW_WIDTH'(READOUT_TIMEOUT_CYCLES - 1);

    state_t state, state_next;

    logic [WINDOW_WIDTH-1:0] cnt;
    logic [WINDOW_WIDTH-1:0] window_len;
    logic                    abort_pending;
    logic                    done_seen;

    logic latch_cfg;
    logic clr_flags;
    logic set_abort;
    logic set_pending;
    logic set_timeout;
    logic set_done;
    logic inc_count;

    always_comb begin
        state_next  = state;
        latch_cfg   = 1'b0;
        clr_flags   = 1'b0;
        set_abort   = 1'b0;
        set_pending = 1'b0;
        set_timeout = 1'b0;
        set_done    = 1'b0;
        inc_count   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (cmd_start && !cmd_abort) begin
                    state_next = S_CLEAR;
                    latch_cfg  = 1'b1;
                    clr_flags  = 1'b1;
                end
            end
            S_CLEAR: begin
                if (cmd_abort) begin
                    state_next = S_IDLE;
                    set_abort  = 1'b1;
                end else if (cnt == CLR_LAST) begin
                    state_next = S_ARM;
                end
            end
            S_ARM: begin
                if (cmd_abort) begin
                    state_next = S_IDLE;
                    set_abort  = 1'b1;
                end else if (cnt == ARM_LAST) begin
                    state_next = S_MEASURE;
                end
            end
            S_MEASURE: begin
                // Abort publishes the partial window and blocks repeat.
                if (cmd_abort) begin
                    state_next  = S_READOUT;
                    set_abort   = 1'b1;
                    set_pending = 1'b1;
                end else if (cnt == window_len - 1'b1) begin
                    state_next = S_READOUT;
                end
            end
            S_READOUT: begin
                if (cmd_abort) begin
                    set_pending = 1'b1;
                end
                if (readout_done) begin
                    state_next = S_RELEASE;
                    set_done   = 1'b1;
                end else if (cnt == TO_LAST) begin
                    state_next  = S_RELEASE;
                    set_timeout = 1'b1;
                end
            end
            S_RELEASE: begin
                inc_count = done_seen;
                if (abort_pending || cmd_abort) begin
                    state_next = S_IDLE;
                    set_abort  = 1'b1;
                end else if (cfg_repeat) begin
                    state_next = S_CLEAR;
                    latch_cfg  = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            window_len    <= '0;
            abort_pending <= 1'b0;
            done_seen     <= 1'b0;
            start         <= 1'b0;
            stop          <= 1'b0;
            clear         <= 1'b0;
            busy          <= 1'b0;
            aborted       <= 1'b0;
            timeout_error <= 1'b0;
            window_count  <= '0;
        end else begin
            state <= state_next;
            // Counter restarts on every state change.
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
            if (latch_cfg) begin
                window_len <= (cfg_window_cycles == '0) ?
                              WINDOW_WIDTH'(1) : cfg_window_cycles;
            end
            if (clr_flags) begin
                aborted       <= 1'b0;
                timeout_error <= 1'b0;
            end
            if (set_abort) begin
                aborted <= 1'b1;
            end
            if (set_timeout) begin
                timeout_error <= 1'b1;
            end
            if (set_pending) begin
                abort_pending <= 1'b1;
            end else if (state_next == S_IDLE || latch_cfg) begin
                abort_pending <= 1'b0;
            end
            done_seen <= set_done;
            if (inc_count) begin
                window_count <= window_count + 1'b1;
            end
            // Outputs follow the next state so they stay registered
            // and are mutually exclusive by construction.
            clear <= (state_next == S_CLEAR);
            start <= (state_next == S_ARM);
            stop  <= (state_next == S_READOUT);
            busy  <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_frequency_measurement_scheduler.sv
// Directed bench for frequency_measurement_scheduler.
// Scenario tasks drive stimulus and compare against hand-computed values.
module tb_frequency_measurement_scheduler;

    logic        clock;
    logic        reset;
    logic [31:0] cfg_window_cycles;
    logic        cfg_repeat;
    logic        cmd_start;
    logic        cmd_abort;
    logic        readout_done;
    logic        start;
    logic        stop;
    logic        clear;
    logic        busy;
    logic        aborted;
    logic        timeout_error;
    logic [15:0] window_count;

    int errors = 0;
    int checks = 0;

    frequency_measurement_scheduler dut (
        .clock             (clock),
        .reset             (reset),
        .cfg_window_cycles (cfg_window_cycles),
        .cfg_repeat        (cfg_repeat),
        .cmd_start         (cmd_start),
        .cmd_abort         (cmd_abort),
        .readout_done      (readout_done),
        .start             (start),
        .stop              (stop),
        .clear             (clear),
        .busy              (busy),
        .aborted           (aborted),
        .timeout_error     (timeout_error),
        .window_count      (window_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic pulse_start();
        @(negedge clock);
        cmd_start = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
    endtask

    // Runs one sequence and measures each phase length in cycles.
    // done_delay < 0 never answers readout; off_win drops cfg_repeat
    // together with the readout_done of that window number.
    task automatic run_seq(input int done_delay, input int off_win,
                           output int nc, output int ns, output int ng,
                           output int nst, output int nw,
                           output int bad, output int hung);
        int stop_run;
        bit stop_seen;
        nc = 0; ns = 0; ng = 0; nst = 0; nw = 0; bad = 0; hung = 1;
        stop_run = 0;
        stop_seen = 1'b0;
        pulse_start();
        for (int i = 0; i < 5000; i++) begin
            readout_done = 1'b0;
            if (!busy) begin
                hung = 0;
                break;
            end
            if (int'(clear) + int'(start) + int'(stop) > 1) bad++;
            if (clear) begin
                nc++;
                stop_seen = 1'b0;
            end
            if (start) ns++;
            if (!clear && !start && !stop && !stop_seen) ng++;
            if (stop) begin
                if (!stop_seen) nw++;
                stop_seen = 1'b1;
                stop_run++;
                nst++;
                if (stop_run == done_delay) begin
                    readout_done = 1'b1;
                    if (nw == off_win) cfg_repeat = 1'b0;
                end
            end else begin
                stop_run = 0;
            end
            @(negedge clock);
        end
        readout_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        reset = 1'b1;
        cfg_window_cycles = 32'd0;
        cfg_repeat = 1'b0;
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        readout_done = 1'b0;
        repeat (3) @(negedge clock);
        obs = {start, stop, clear, busy, aborted, timeout_error, window_count};
        checks++;
        if (obs !== 22'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", obs);
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b want=0", busy);
        end
    endtask

    task automatic test_single_shot();
        int nc, ns, ng, nst, nw, bad, hung;
        cfg_window_cycles = 32'd100;
        cfg_repeat = 1'b0;
        run_seq(5, 0, nc, ns, ng, nst, nw, bad, hung);
        checks++;
        if (hung !== 0) begin
            errors++;
            $display("FAIL single_hung got=%0d want=0", hung);
        end
        checks++;
        if (nc !== 4 || ns !== 2) begin
            errors++;
            $display("FAIL single_pulses clear=%0d start=%0d want 4 2", nc, ns);
        end
        checks++;
        if (ng !== 100) begin
            errors++;
            $display("FAIL single_window got=%0d want=100", ng);
        end
        checks++;
        if (nst !== 5 || nw !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL single_stop stop=%0d win=%0d excl=%0d want 5 1 0",
                     nst, nw, bad);
        end
        checks++;
        if (window_count !== 16'd1) begin
            errors++;
            $display("FAIL single_count got=%0d want=1", window_count);
        end
    endtask

    task automatic test_back_to_back();
        int nc, ns, ng, nst, nw, bad, hung;
        cfg_window_cycles = 32'd10;
        cfg_repeat = 1'b1;
        run_seq(3, 3, nc, ns, ng, nst, nw, bad, hung);
        checks++;
        if (hung !== 0 || nw !== 3) begin
            errors++;
            $display("FAIL repeat_windows hung=%0d win=%0d want 0 3", hung, nw);
        end
        checks++;
        if (nc !== 12 || ns !== 6 || ng !== 30 || nst !== 9 || bad !== 0) begin
            errors++;
            $display("FAIL repeat_phases c=%0d s=%0d g=%0d st=%0d x=%0d want 12 6 30 9 0",
                     nc, ns, ng, nst, bad);
        end
        checks++;
        if (window_count !== 16'd4) begin
            errors++;
            $display("FAIL repeat_count got=%0d want=4", window_count);
        end
    endtask

    task automatic test_timeout();
        int nc, ns, ng, nst, nw, bad, hung;
        cfg_window_cycles = 32'd20;
        cfg_repeat = 1'b0;
        run_seq(-1, 0, nc, ns, ng, nst, nw, bad, hung);
        checks++;
        if (hung !== 0 || nst !== 1024) begin
            errors++;
            $display("FAIL timeout_stop_len got=%0d hung=%0d want 1024 0", nst, hung);
        end
        checks++;
        if (timeout_error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flag got=%b want=1", timeout_error);
        end
        checks++;
        if (window_count !== 16'd4) begin
            errors++;
            $display("FAIL timeout_count got=%0d want=4", window_count);
        end
    endtask

    task automatic test_abort_measure();
        int gap;
        int busy_hits;
        cfg_window_cycles = 32'd100;
        cfg_repeat = 1'b1;
        gap = 0;
        pulse_start();
        checks++;
        if (timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_timeout got=%b want=0", timeout_error);
        end
        for (int i = 0; i < 200 && gap < 5; i++) begin
            @(negedge clock);
            if (busy && !clear && !start && !stop) gap++;
        end
        cmd_abort = 1'b1;
        @(negedge clock);
        cmd_abort = 1'b0;
        checks++;
        if (stop !== 1'b1 || aborted !== 1'b1 || gap !== 5) begin
            errors++;
            $display("FAIL abort_measure stop=%b aborted=%b gap=%0d want 1 1 5",
                     stop, aborted, gap);
        end
        @(negedge clock);
        readout_done = 1'b1;
        @(negedge clock);
        readout_done = 1'b0;
        busy_hits = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (busy || clear) busy_hits++;
        end
        checks++;
        if (busy_hits !== 0 || window_count !== 16'd5) begin
            errors++;
            $display("FAIL abort_no_repeat busy_cycles=%0d count=%0d want 0 5",
                     busy_hits, window_count);
        end
        cfg_repeat = 1'b0;
    endtask

    task automatic test_abort_arm();
        int stop_hits;
        cfg_window_cycles = 32'd100;
        stop_hits = 0;
        pulse_start();
        for (int i = 0; i < 20 && !start; i++) begin
            @(negedge clock);
            if (stop) stop_hits++;
        end
        cmd_abort = 1'b1;
        @(negedge clock);
        cmd_abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || start !== 1'b0 || aborted !== 1'b1) begin
            errors++;
            $display("FAIL abort_arm busy=%b start=%b aborted=%b want 0 0 1",
                     busy, start, aborted);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (stop) stop_hits++;
        end
        checks++;
        if (stop_hits !== 0) begin
            errors++;
            $display("FAIL abort_arm_stop got=%0d want=0", stop_hits);
        end
    endtask

    task automatic test_window_zero();
        int nc, ns, ng, nst, nw, bad, hung;
        cfg_window_cycles = 32'd0;
        run_seq(2, 0, nc, ns, ng, nst, nw, bad, hung);
        checks++;
        if (hung !== 0 || ng !== 1) begin
            errors++;
            $display("FAIL window_zero got=%0d hung=%0d want 1 0", ng, hung);
        end
        checks++;
        if (window_count !== 16'd6 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL window_zero_state count=%0d aborted=%b want 6 0",
                     window_count, aborted);
        end
    endtask

    task automatic test_start_abort_same();
        int busy_hits;
        busy_hits = 0;
        @(negedge clock);
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        @(negedge clock);
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (busy || clear) busy_hits++;
            @(negedge clock);
        end
        checks++;
        if (busy_hits !== 0) begin
            errors++;
            $display("FAIL start_abort_same busy_cycles=%0d want=0", busy_hits);
        end
    endtask

    task automatic test_reset_readout();
        int nc, ns, ng, nst, nw, bad, hung;
        cfg_window_cycles = 32'd50;
        pulse_start();
        for (int i = 0; i < 200 && !stop; i++) @(negedge clock);
        checks++;
        if (stop !== 1'b1) begin
            errors++;
            $display("FAIL reset_reach_readout stop=%b want=1", stop);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (stop !== 1'b0 || busy !== 1'b0 || window_count !== 16'd0) begin
            errors++;
            $display("FAIL async_reset stop=%b busy=%b count=%0d want 0 0 0",
                     stop, busy, window_count);
        end
        @(negedge clock);
        reset = 1'b0;
        cfg_window_cycles = 32'd7;
        run_seq(2, 0, nc, ns, ng, nst, nw, bad, hung);
        checks++;
        if (hung !== 0 || ng !== 7 || nst !== 2 || window_count !== 16'd1) begin
            errors++;
            $display("FAIL after_reset gap=%0d stop=%0d count=%0d want 7 2 1",
                     ng, nst, window_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_back_to_back();
        test_timeout();
        test_abort_measure();
        test_abort_arm();
        test_window_zero();
        test_start_abort_same();
        test_reset_readout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
